// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu arbiter slice.
// Opcode and FSM state enums plus ALU latency constants.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        AND = 3'd2,
        XOR = 3'd3,
        MUL = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } arb_state_e;

    localparam int MUL_LAT = 4;
    localparam int SC_LAT  = 1;

endpackage

// File: rtl/tinyalu_arbiter_rr_grant.sv
// Combinational round-robin picker: first request at or after i_ptr.
// Ports: i_req (requests), i_ptr (start index), o_grant (one-hot),
//        o_idx (granted index), o_any (some request present).
module rr_grant #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        int   j;
        logic found;
        j       = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        for (int k = 0; k < N; k++) begin
            // Walk the ring starting at the pointer, wrapping at N.
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && i_req[W'(j)]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Round-robin sequencer sharing one tinyalu between NREQ requesters.
// Ports: req_* command valid/ready + operands, rsp_* tagged responses,
//        alu_* start/operand/done handshake to the ALU, clk/reset.
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [15:0]       rsp_result,
    output logic              rsp_error,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_start,
    output logic              alu_reset_n,
    input  logic              alu_done,
    input  logic [15:0]       alu_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e      r_state;
    arb_state_e      w_next;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [2:0]      r_op;
    logic [IW-1:0]   r_tag;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_result;
    logic            r_error;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;
    logic [2:0]      w_sel_op;
    logic [IW-1:0]   w_ptr_nxt;
    logic            w_accept;
    logic            w_timeout;
    logic            w_rsp_take;

    rr_grant #(.N(NREQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_a    = req_a[8*w_idx +: 8];
    assign w_sel_b    = req_b[8*w_idx +: 8];
    assign w_sel_op   = req_op[3*w_idx +: 3];
    assign w_accept   = (r_state == IDLE) && w_any;
    assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
    assign w_rsp_take = rsp_ready[r_tag];
    assign w_ptr_nxt  = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign alu_reset_n = ~reset;
    assign rsp_result  = r_result;
    assign rsp_error   = r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        alu_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready = w_grant;
                    // A NOP never touches the ALU.
                    w_next = (w_sel_op == NOP) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                alu_start = 1'b1;
                if (alu_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[r_tag] = 1'b1;
                if (w_rsp_take) begin
                    w_next = (r_op == NOP) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                // start low for a cycle so the ALU done flag clears
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                        r_op  <= w_sel_op;
                        r_tag <= w_idx;
                        r_ptr <= w_ptr_nxt;
                        if (w_sel_op == NOP) begin
                            r_result <= '0;
                            r_error  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                end
                WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_error  <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Self-checking bench for tinyalu_arbiter with a behavioural ALU stub.
// Expected values come from a plain-arithmetic reference model.
module tb_tinyalu_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_error;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_ptr = 0;
    logic alu_stuck = 1'b0;
    logic [2:0] alu_cnt;

    always #5 clk = ~clk;

    tinyalu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_reset_n (alu_reset_n),
        .alu_done    (alu_done),
        .alu_result  (alu_result)
    );

    // ALU stub: counts edges with start high; done when latency reached.
    always_ff @(posedge clk or negedge alu_reset_n) begin
        if (!alu_reset_n) begin
            alu_cnt <= '0;
        end else if (!alu_start) begin
            alu_cnt <= '0;
        end else if (alu_cnt != 3'd7) begin
            alu_cnt <= alu_cnt + 3'd1;
        end
    end

    always_comb begin
        alu_done = alu_start && !alu_stuck &&
                   (int'(alu_cnt) == (alu_op[2] ? 4 : 1));
        alu_result = '0;
        case (alu_op)
            3'd1:    alu_result = 16'(alu_a) + 16'(alu_b);
            3'd2:    alu_result = {8'h00, alu_a & alu_b};
            3'd3:    alu_result = {8'h00, alu_a ^ alu_b};
            3'd4:    alu_result = 16'(alu_a) * 16'(alu_b);
            default: alu_result = '0;
        endcase
    end

    function automatic logic [15:0] model_res(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [2:0] op);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            3'd1:    return 16'(ia + ib);
            3'd2:    return 16'(a & b);
            3'd3:    return 16'(a ^ b);
            3'd4:    return 16'(ia * ib);
            default: return 16'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        if (op == 3'd0) return 1;
        return op[2] ? 6 : 3;
    endfunction

    function automatic int model_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Drives one command from requester r and observes it to completion.
    task automatic run_cmd(input int r, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op,
                           output int lat, output int nstart,
                           output logic [15:0] res, output logic err,
                           output logic [3:0] vbits, output bit stable,
                           output bit hung);
        int t;
        bit got;
        hung = 0; lat = 0; nstart = 0; stable = 1;
        res = '0; err = 1'b0; vbits = '0; got = 0; t = 0;
        req_a[8*r +: 8]  = a;
        req_b[8*r +: 8]  = b;
        req_op[3*r +: 3] = op;
        req_valid[r]     = 1'b1;
        #1;
        while (!req_ready[r] && t < 40) begin
            @(negedge clk); #1; t++;
        end
        if (!req_ready[r]) begin
            hung = 1;
            req_valid[r] = 1'b0;
            return;
        end
        model_ptr = (r + 1) % NREQ;
        @(negedge clk);
        req_valid[r] = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            if (alu_start) begin
                nstart++;
                if (alu_a !== a || alu_b !== b || alu_op !== op) stable = 0;
            end
            if (rsp_valid != 0) begin
                got = 1; lat = k; vbits = rsp_valid;
                res = rsp_result; err = rsp_error;
                rsp_ready[r] = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready[r] = 1'b0;
        if (!got) hung = 1;
    endtask

    task automatic test_reset();
        logic [50:0] outs;
        reset = 1'b1;
        #2;
        outs = {req_ready, rsp_valid, alu_start, rsp_error,
                rsp_result, alu_a, alu_b, alu_op};
        n_tests++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h want 0", outs);
        end
        n_tests++;
        if (alu_reset_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_alu_n: got %b want 0", alu_reset_n);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, alu_start} !== '0) begin
            n_fail++;
            $display("FAIL idle_outs: got %h want 0",
                     {req_ready, rsp_valid, alu_start});
        end
    endtask

    task automatic test_add();
        int lat, ns; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung;
        run_cmd(0, 8'hFF, 8'h01, 3'd1, lat, ns, res, err, vb, st, hung);
        n_tests++;
        if (hung !== 0) begin n_fail++; $display("FAIL add_hung: got 1 want 0"); end
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL add_lat: got %0d want 3", lat); end
        n_tests++;
        if (ns !== 2) begin n_fail++; $display("FAIL add_start: got %0d want 2", ns); end
        n_tests++;
        if (res !== 16'h0100 || err !== 1'b0) begin
            n_fail++; $display("FAIL add_res: got %h/%b want 0100/0", res, err);
        end
        n_tests++;
        if (vb !== 4'b0001) begin n_fail++; $display("FAIL add_tag: got %b want 0001", vb); end
    endtask

    task automatic test_mul();
        int lat, ns; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung;
        run_cmd(1, 8'hFF, 8'hFF, 3'd4, lat, ns, res, err, vb, st, hung);
        n_tests++;
        if (lat !== 6) begin n_fail++; $display("FAIL mul_lat: got %0d want 6", lat); end
        n_tests++;
        if (ns !== 5) begin n_fail++; $display("FAIL mul_start: got %0d want 5", ns); end
        n_tests++;
        if (st !== 1) begin n_fail++; $display("FAIL mul_stable: got 0 want 1"); end
        n_tests++;
        if (res !== 16'hFE01 || err !== 1'b0) begin
            n_fail++; $display("FAIL mul_res: got %h/%b want FE01/0", res, err);
        end
        n_tests++;
        if (vb !== 4'b0010 || hung !== 0) begin
            n_fail++; $display("FAIL mul_tag: got %b want 0010", vb);
        end
    endtask

    task automatic test_nop();
        int lat, ns; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung;
        run_cmd(2, 8'($urandom), 8'($urandom), 3'd0,
                lat, ns, res, err, vb, st, hung);
        n_tests++;
        if (lat !== 1 || hung !== 0) begin
            n_fail++; $display("FAIL nop_lat: got %0d want 1", lat);
        end
        n_tests++;
        if (ns !== 0) begin n_fail++; $display("FAIL nop_start: got %0d want 0", ns); end
        n_tests++;
        if (res !== 16'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL nop_res: got %h/%b want 0000/1", res, err);
        end
        n_tests++;
        if (vb !== 4'b0100) begin n_fail++; $display("FAIL nop_tag: got %b want 0100", vb); end
    endtask

    task automatic test_timeout();
        int lat, ns; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung;
        logic [7:0] a, b;
        alu_stuck = 1'b1;
        run_cmd(3, 8'h12, 8'h34, 3'd1, lat, ns, res, err, vb, st, hung);
        alu_stuck = 1'b0;
        n_tests++;
        if (lat !== TIMEOUT + 2 || hung !== 0) begin
            n_fail++; $display("FAIL to_lat: got %0d want %0d", lat, TIMEOUT + 2);
        end
        n_tests++;
        if (ns !== TIMEOUT + 1) begin
            n_fail++; $display("FAIL to_start: got %0d want %0d", ns, TIMEOUT + 1);
        end
        n_tests++;
        if (res !== 16'h0 || err !== 1'b1) begin
            n_fail++; $display("FAIL to_res: got %h/%b want 0000/1", res, err);
        end
        a = 8'($urandom); b = 8'($urandom);
        run_cmd(3, a, b, 3'd2, lat, ns, res, err, vb, st, hung);
        n_tests++;
        if (lat !== 3 || res !== model_res(a, b, 3'd2) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_next: got %0d/%h/%b want 3/%h/0",
                     lat, res, err, model_res(a, b, 3'd2));
        end
    endtask

    task automatic test_all_valid();
        logic [7:0] ca [4];
        logic [7:0] cb [4];
        int exp, t;
        logic [15:0] eres;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            ca[i] = 8'($urandom); cb[i] = 8'($urandom);
            req_a[8*i +: 8] = ca[i];
            req_b[8*i +: 8] = cb[i];
            req_op[3*i +: 3] = 3'd3;
        end
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            t = 0;
            while (req_ready == 0 && t < 20) begin
                @(negedge clk); #1; t++;
            end
            exp = model_pick(req_valid, model_ptr);
            n_tests++;
            if (req_ready !== 4'(1 << exp)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b",
                         g, req_ready, 4'(1 << exp));
            end
            eres = model_res(ca[exp], cb[exp], 3'd3);
            model_ptr = (exp + 1) % NREQ;
            @(negedge clk);
            if (g < 4) begin
                ca[exp] = 8'($urandom); cb[exp] = 8'($urandom);
                req_a[8*exp +: 8] = ca[exp];
                req_b[8*exp +: 8] = cb[exp];
            end else begin
                req_valid = '0;
            end
            t = 0;
            while (rsp_valid == 0 && t < 20) begin
                @(negedge clk); t++;
            end
            n_tests++;
            if (rsp_valid !== 4'(1 << exp) || rsp_result !== eres ||
                rsp_error !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got %b/%h want %b/%h",
                         g, rsp_valid, rsp_result, 4'(1 << exp), eres);
            end
            rsp_ready = ~(4'(1 << exp));
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 4'(1 << exp)) begin
                n_fail++;
                $display("FAIL rr_hold%0d: got %b want %b",
                         g, rsp_valid, 4'(1 << exp));
            end
            rsp_ready = 4'(1 << exp);
            @(negedge clk);
            rsp_ready = '0;
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int lat, ns, t; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung, seen;
        logic [50:0] outs;
        req_a[15:8] = 8'hFF; req_b[15:8] = 8'hFF; req_op[5:3] = 3'd4;
        req_valid[1] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[1] && t < 20) begin
            @(negedge clk); #1; t++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (alu_start !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got %b want 1", alu_start);
        end
        #2 reset = 1'b1;
        #1;
        outs = {req_ready, rsp_valid, alu_start, rsp_error,
                rsp_result, alu_a, alu_b, alu_op};
        n_tests++;
        if (outs !== '0 || alu_reset_n !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got %h want 0", outs);
        end
        model_ptr = 0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid != 0 || alu_start) seen = 1;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_norsp: got 1 want 0"); end
        req_a[31:24] = 8'd1; req_b[31:24] = 8'd1; req_op[11:9] = 3'd1;
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd4; req_op[2:0] = 3'd1;
        req_valid = 4'b1001;
        #1;
        n_tests++;
        if (req_ready !== 4'(1 << model_pick(req_valid, model_ptr))) begin
            n_fail++; $display("FAIL rst_ptr: got %b want 0001", req_ready);
        end
        req_valid[3] = 1'b0;
        run_cmd(0, 8'd3, 8'd4, 3'd1, lat, ns, res, err, vb, st, hung);
        n_tests++;
        if (res !== 16'd7 || err !== 1'b0 || lat !== 3 || hung !== 0) begin
            n_fail++; $display("FAIL rst_add: got %h/%0d want 0007/3", res, lat);
        end
    endtask

    task automatic test_random();
        int lat, ns, r; logic [15:0] res; logic err; logic [3:0] vb;
        bit st, hung;
        logic [7:0] a, b; logic [2:0] op;
        for (int i = 0; i < 24; i++) begin
            r  = $urandom_range(0, NREQ - 1);
            op = 3'($urandom_range(0, 4));
            a  = 8'($urandom); b = 8'($urandom);
            run_cmd(r, a, b, op, lat, ns, res, err, vb, st, hung);
            n_tests++;
            if (hung !== 0 || vb !== 4'(1 << r)) begin
                n_fail++; $display("FAIL rnd_tag%0d: got %b want %b", i, vb, 4'(1 << r));
            end
            n_tests++;
            if (res !== model_res(a, b, op) || err !== (op == 3'd0)) begin
                n_fail++;
                $display("FAIL rnd_res%0d: op %0d got %h/%b want %h",
                         i, op, res, err, model_res(a, b, op));
            end
            n_tests++;
            if (lat !== model_lat(op) || st !== 1) begin
                n_fail++;
                $display("FAIL rnd_lat%0d: op %0d got %0d want %0d",
                         i, op, lat, model_lat(op));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        test_reset();
        test_add();
        test_mul();
        test_nop();
        test_timeout();
        test_all_valid();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
